proc_mem_arbiter: RTL and testbench
===================================

Name: proc_mem_arbiter

Overview:
- Parametrised shared-memory front end for N processor cores.
- Each core drives its own READ/WRITE/ADDR/DATA request port.
- The block grants one core at a time, round-robin, and drives a single memory port with a configurable access latency.
- Returns a per-core ACK pulse and read data. Sits between the processor tops and the memory model in multi-core builds.

Parameters:
- N_PORTS, 2, number of requesting cores (≥2).
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 26, address bus width.
- MEM_LATENCY, 2, cycles the memory command is held before data is captured (≥1).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_READ  input  N_PORTS  per-core read request (level).
- REQ_WRITE  input  N_PORTS  per-core write request (level).
- REQ_ADDR  input  N_PORTS*ADDR_WIDTH  packed addresses; core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_WDATA  input  N_PORTS*DATA_WIDTH  packed write data, same packing.
- REQ_ACK  output  N_PORTS  one-cycle completion pulse to granted core.
- REQ_RDATA  output  DATA_WIDTH  read data, valid while the matching ACK is high.
- GRANT_ID  output  clog2(N_PORTS)  index of the core currently or last served.
- BUSY  output  1  high in ACCESS and DONE.
- MEM_ADDR  output  ADDR_WIDTH  memory address.
- MEM_DATA_OUT  output  DATA_WIDTH  memory write data.
- MEM_DATA_IN  input  DATA_WIDTH  memory read data.
- MEM_READ  output  1  memory read strobe.
- MEM_WRITE  output  1  memory write strobe.

Behaviour:
- Reset: all outputs are registered and go to 0 (MEM_*, REQ_ACK, REQ_RDATA, GRANT_ID, BUSY). State goes to IDLE. Round-robin pointer last = N_PORTS-1, so core 0 wins first.
- Core i is pending when REQ_READ[i] | REQ_WRITE[i]. If both are high, the access is a write and the read is ignored.
- FSM IDLE:
  - Search pending cores starting at (last+1) mod N_PORTS, wrapping; first hit = g.
  - At the edge: latch g, addr, wdata and op; set last = g and GRANT_ID = g; go to ACCESS with cnt = 1.
  - Drive MEM_READ (read) or MEM_WRITE (write), MEM_ADDR, and MEM_DATA_OUT (write only; 0 for reads). Set BUSY = 1.
  - With no pending core, stay in IDLE with all strobes at 0.
- FSM ACCESS:
  - Hold strobes, MEM_ADDR and MEM_DATA_OUT constant for exactly MEM_LATENCY cycles.
  - At the edge where cnt == MEM_LATENCY: for reads, REQ_RDATA <= MEM_DATA_IN.
  - Same edge: drop strobes, set REQ_ACK[g] = 1, go to DONE. Otherwise cnt++.
- FSM DONE: lasts one cycle. ACK[g] is high and REQ_RDATA is valid. At the next edge ACK goes to 0, BUSY goes to 0, state returns to IDLE.
- REQ_RDATA holds its value until the next read completes. It is not updated by writes.
- Timing: request sampled at edge E0 → strobes high E0..E(MEM_LATENCY) → ACK high E(MEM_LATENCY)..E(MEM_LATENCY+1). Throughput is one access per MEM_LATENCY+2 cycles.
- Requests are level-sensitive and sampled only in IDLE. A core must deassert during its ACK cycle to avoid being re-sampled as a new request.
  - A core still requesting in the IDLE cycle after its own ACK is treated as a new request.
  - It competes fairly: other pending cores win first.
- Changes on any REQ_* input during ACCESS/DONE are ignored; the latched transaction completes unchanged.
- Exactly one REQ_ACK bit is ever high, and only in DONE.
- RST asserted mid-transaction aborts it: no ACK, strobes to 0 at that edge, pointer reset.
- Widths: GRANT_ID has width clog2(N_PORTS) (minimum 1). cnt is sized to hold MEM_LATENCY.

Test Plan:
- Reset check: RST high 2 cycles with REQ_READ=2'b11 → all outputs 0. First grant after release goes to core 0 (GRANT_ID=0).
- Single read, N=2, L=2: core1 reads 0x0000010, memory returns 0xDEADBEEF.
  - MEM_READ high for exactly 2 cycles with MEM_ADDR=0x10.
  - REQ_ACK=2'b10 for 1 cycle; REQ_RDATA=0xDEADBEEF in that cycle and after.
- Fairness: both cores hold read requests continuously, each deasserting only after its ACK.
  - Grants alternate 0,1,0,1, each 4 cycles apart.
  - No core is granted twice in a row while the other is pending.
- Write priority/overlap: core0 asserts READ and WRITE with addr 0x20, wdata 0x12345678.
  - MEM_WRITE=1, MEM_READ=0, MEM_DATA_OUT=0x12345678 for L cycles.
  - REQ_RDATA keeps its prior value.
- Input change mid-access: core0 read at 0x30; during ACCESS, core0 changes addr to 0x40 and drops READ.
  - MEM_ADDR stays 0x30 throughout.
  - ACK still issued after L cycles.
- Reset mid-access, plus parameter sweep N=4, L=1:
  - RST pulsed in ACCESS → no ACK, MEM_READ=0 next cycle.
  - After restart, all 4 cores requesting → grant order 0,1,2,3, one ACK every 3 cycles.

Source files
------------

// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter
// ----------------
// Shared-memory front end for N_PORTS processor cores. One core at a time is
// granted round-robin; the granted request drives a single memory port for
// MEM_LATENCY cycles, then the core gets a one-cycle ACK together with the
// read data (reads only).
//
// Request handshake: a core raises REQ_READ and/or REQ_WRITE (level) with
// REQ_ADDR/REQ_WDATA stable. The arbiter samples requests only while idle.
// The request is complete when REQ_ACK[core] pulses for exactly one cycle.
// During that cycle REQ_RDATA is valid. The core must drop its request during
// the ACK cycle, or it is taken as a new request in the next idle cycle.
// WRITE wins over READ when both are high.
//
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   REQ_READ      [N_PORTS]              per-core read request
//   REQ_WRITE     [N_PORTS]              per-core write request
//   REQ_ADDR      [N_PORTS*ADDR_WIDTH]   packed addresses, core i at i*ADDR_WIDTH
//   REQ_WDATA     [N_PORTS*DATA_WIDTH]   packed write data, same packing
//   REQ_ACK       [N_PORTS]              one-cycle completion pulse
//   REQ_RDATA     [DATA_WIDTH]           read data, held until the next read
//   GRANT_ID      [GW]                   core currently / last served
//   BUSY                                 high while in ACCESS or DONE
//   MEM_ADDR, MEM_DATA_OUT, MEM_READ, MEM_WRITE   memory command
//   MEM_DATA_IN                          memory read data
//   dbg_state     [2]                    FSM state (0 idle, 1 access, 2 done)

module proc_mem_arbiter #(
  parameter int N_PORTS     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int MEM_LATENCY = 2,
  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [N_PORTS-1:0]             REQ_READ,
  input  logic [N_PORTS-1:0]             REQ_WRITE,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  REQ_WDATA,
  output logic [N_PORTS-1:0]             REQ_ACK,
  output logic [DATA_WIDTH-1:0]          REQ_RDATA,
  output logic [GW-1:0]                  GRANT_ID,
  output logic                           BUSY,
  output logic [ADDR_WIDTH-1:0]          MEM_ADDR,
  output logic [DATA_WIDTH-1:0]          MEM_DATA_OUT,
  input  logic [DATA_WIDTH-1:0]          MEM_DATA_IN,
  output logic                           MEM_READ,
  output logic                           MEM_WRITE,
  output logic [1:0]                     dbg_state
);

  // Counter must be able to hold MEM_LATENCY itself.
  localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]            state;
  logic [GW-1:0]         last;
  logic [CW-1:0]         cnt;

  logic [N_PORTS-1:0]    pending;
  logic                  found;
  logic [GW-1:0]         pick;
  logic                  pick_write;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic [N_PORTS-1:0]    grant_onehot;

  assign pending   = REQ_READ | REQ_WRITE;
  assign dbg_state = state;

  // Round-robin search: start one past the last served core and wrap, so
  // the core just served is considered last.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = (int'(last) + k) % N_PORTS;
      if (!found && pending[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  assign pick_write = REQ_WRITE[pick];
  assign pick_addr  = REQ_ADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
  assign pick_wdata = REQ_WDATA[pick*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    grant_onehot           = '0;
    grant_onehot[GRANT_ID] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_IDLE;
      last         <= GW'(N_PORTS - 1);
      cnt          <= '0;
      REQ_ACK      <= '0;
      REQ_RDATA    <= '0;
      GRANT_ID     <= '0;
      BUSY         <= 1'b0;
      MEM_ADDR     <= '0;
      MEM_DATA_OUT <= '0;
      MEM_READ     <= 1'b0;
      MEM_WRITE    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          REQ_ACK <= '0;
          if (found) begin
            state    <= ST_ACCESS;
            cnt      <= CW'(1);
            last     <= pick;
            GRANT_ID <= pick;
            BUSY     <= 1'b1;
            MEM_ADDR <= pick_addr;
            if (pick_write) begin
              MEM_WRITE    <= 1'b1;
              MEM_READ     <= 1'b0;
              MEM_DATA_OUT <= pick_wdata;
            end else begin
              MEM_WRITE    <= 1'b0;
              MEM_READ     <= 1'b1;
              MEM_DATA_OUT <= '0;
            end
          end else begin
            BUSY      <= 1'b0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
          end
        end

        // The memory command registers already hold the latched transaction,
        // so nothing on REQ_* can disturb it from here on.
        ST_ACCESS: begin
          if (cnt == CW'(MEM_LATENCY)) begin
            if (MEM_READ) begin
              REQ_RDATA <= MEM_DATA_IN;
            end
            MEM_READ     <= 1'b0;
            MEM_WRITE    <= 1'b0;
            MEM_ADDR     <= '0;
            MEM_DATA_OUT <= '0;
            REQ_ACK      <= grant_onehot;
            state        <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          REQ_ACK <= '0;
          BUSY    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          REQ_ACK   <= '0;
          BUSY      <= 1'b0;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Testbench for proc_mem_arbiter: instance A (2 cores, latency 2) and
// instance B (4 cores, latency 1). Expected ACK/read-data and memory commands
// are queued by the driver; monitors pop and compare when the DUT presents them.

module tb_proc_mem_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LA = 2;
  localparam int LB = 1;

  logic clk;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Instance A signals
  logic            rst_a;
  logic [1:0]      rd_a, wr_a, ack_a;
  logic [2*AW-1:0] addr_a;
  logic [2*DW-1:0] wdata_a;
  logic [DW-1:0]   rdata_a, mdout_a, mdin_a;
  logic [0:0]      gid_a;
  logic            busy_a, mrd_a, mwr_a;
  logic [AW-1:0]   maddr_a;
  logic [1:0]      st_a;

  // Instance B signals
  logic            rst_b;
  logic [3:0]      rd_b, wr_b, ack_b;
  logic [4*AW-1:0] addr_b;
  logic [4*DW-1:0] wdata_b;
  logic [DW-1:0]   rdata_b, mdout_b, mdin_b;
  logic [1:0]      gid_b;
  logic            busy_b, mrd_b, mwr_b;
  logic [AW-1:0]   maddr_b;
  logic [1:0]      st_b;

  // Scoreboard queues
  logic [33:0] exp_ack_a[$];   // {ack[1:0], rdata}
  logic [35:0] exp_ack_b[$];   // {ack[3:0], rdata}
  logic [59:0] exp_mem_a[$];   // {rd, wr, addr, data_out}

  proc_mem_arbiter #(.N_PORTS(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LA)) dut_a (
    .CLK(clk), .RST(rst_a), .REQ_READ(rd_a), .REQ_WRITE(wr_a), .REQ_ADDR(addr_a),
    .REQ_WDATA(wdata_a), .REQ_ACK(ack_a), .REQ_RDATA(rdata_a), .GRANT_ID(gid_a),
    .BUSY(busy_a), .MEM_ADDR(maddr_a), .MEM_DATA_OUT(mdout_a), .MEM_DATA_IN(mdin_a),
    .MEM_READ(mrd_a), .MEM_WRITE(mwr_a), .dbg_state(st_a)
  );

  proc_mem_arbiter #(.N_PORTS(4), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LB)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ_READ(rd_b), .REQ_WRITE(wr_b), .REQ_ADDR(addr_b),
    .REQ_WDATA(wdata_b), .REQ_ACK(ack_b), .REQ_RDATA(rdata_b), .GRANT_ID(gid_b),
    .BUSY(busy_b), .MEM_ADDR(maddr_b), .MEM_DATA_OUT(mdout_b), .MEM_DATA_IN(mdin_b),
    .MEM_READ(mrd_b), .MEM_WRITE(mwr_b), .dbg_state(st_b)
  );

  // Clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input bit sel_b, input logic [3:0] mask, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sel_b ? ((ack_b & mask) != 4'd0) : (({2'b00, ack_a} & mask) != 4'd0)) begin
        t = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout: got no ack in 20 cycles expected ack mask 0x%0h", mask);
  endtask

  // Monitor A: ACK/read data and memory command
  initial begin
    logic [33:0] e;
    logic [59:0] cur;
    bit          active;
    int          len;
    active = 1'b0;
    len    = 0;
    cur    = '1;
    forever begin
      @(negedge clk);
      if (ack_a != 2'b00) begin
        if (exp_ack_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_a_unexpected: got ack=%b expected none", ack_a);
        end else begin
          e = exp_ack_a.pop_front();
          check("ack_a", {30'd0, ack_a, rdata_a}, {30'd0, e});
        end
      end
      if (mrd_a || mwr_a) begin
        if (!active) begin
          active = 1'b1;
          len    = 0;
          if (exp_mem_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_a_unexpected: got addr=0x%0h expected no command", maddr_a);
            cur = '1;
          end else begin
            cur = exp_mem_a.pop_front();
          end
        end
        len++;
        check("mem_cmd_a", {4'd0, mrd_a, mwr_a, maddr_a, mdout_a}, {4'd0, cur});
      end else if (active) begin
        active = 1'b0;
        check("mem_len_a", len, LA);
      end
    end
  end

  // Monitor B: ACK/read data
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (ack_b != 4'b0000) begin
        if (exp_ack_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_b_unexpected: got ack=%b expected none", ack_b);
        end else begin
          e = exp_ack_b.pop_front();
          check("ack_b", {28'd0, ack_b, rdata_b}, {28'd0, e});
        end
      end
    end
  end

  // Stimulus
  initial begin
    int t, t0, t1;
    rst_a = 1'b1; rd_a = 2'b11; wr_a = 2'b00; addr_a = '0; wdata_a = '0;
    mdin_a = 32'h0BADF00D;
    rst_b = 1'b1; rd_b = 4'b0000; wr_b = 4'b0000; addr_b = '0; wdata_b = '0;
    mdin_b = '0;

    // Reset with both cores requesting
    tick();
    tick();
    check("rst_ack", ack_a, 0);
    check("rst_rdata", rdata_a, 0);
    check("rst_gid", gid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_mem", {mrd_a, mwr_a, maddr_a, mdout_a}, 0);

    // First grant after release goes to core 0
    exp_ack_a.push_back({2'b01, 32'h0BADF00D});
    exp_mem_a.push_back({1'b1, 1'b0, 26'h0, 32'h0});
    rst_a = 1'b0;
    tick();
    check("first_gid", gid_a, 0);
    check("first_busy", busy_a, 1);
    check("first_state", st_a, 1);
    wait_ack(1'b0, 4'b0001, t);
    rd_a = 2'b00;

    // Single read from core 1
    tick();
    mdin_a = 32'hDEADBEEF;
    addr_a[AW +: AW] = 26'h10;
    rd_a = 2'b10;
    exp_ack_a.push_back({2'b10, 32'hDEADBEEF});
    exp_mem_a.push_back({1'b1, 1'b0, 26'h10, 32'h0});
    wait_ack(1'b0, 4'b0010, t);
    check("read_gid", gid_a, 1);
    rd_a = 2'b00;
    mdin_a = 32'h0;
    tick();
    tick();
    tick();
    check("rdata_hold", rdata_a, 32'hDEADBEEF);
    check("idle_busy", busy_a, 0);

    // Fairness: both cores request continuously
    mdin_a = 32'h11112222;
    addr_a = {26'h104, 26'h100};
    rd_a = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_ack_a.push_back({2'b01, 32'h11112222});
      exp_mem_a.push_back({1'b1, 1'b0, 26'h100, 32'h0});
      exp_ack_a.push_back({2'b10, 32'h11112222});
      exp_mem_a.push_back({1'b1, 1'b0, 26'h104, 32'h0});
    end
    wait_ack(1'b0, 4'b0011, t0);
    for (int i = 1; i < 4; i++) begin
      wait_ack(1'b0, 4'b0011, t1);
      check("fair_spacing", t1 - t0, 4);
      t0 = t1;
    end
    rd_a = 2'b00;

    // Read+write on core 0: write wins, read data untouched
    tick();
    mdin_a = 32'hFFFFFFFF;
    addr_a[0 +: AW] = 26'h20;
    wdata_a[0 +: DW] = 32'h12345678;
    rd_a = 2'b01;
    wr_a = 2'b01;
    exp_ack_a.push_back({2'b01, 32'h11112222});
    exp_mem_a.push_back({1'b0, 1'b1, 26'h20, 32'h12345678});
    wait_ack(1'b0, 4'b0001, t);
    rd_a = 2'b00;
    wr_a = 2'b00;
    tick();
    check("wr_rdata_keep", rdata_a, 32'h11112222);

    // Inputs change during access: latched transaction completes unchanged
    tick();
    mdin_a = 32'h30303030;
    addr_a[0 +: AW] = 26'h30;
    rd_a = 2'b01;
    exp_ack_a.push_back({2'b01, 32'h30303030});
    exp_mem_a.push_back({1'b1, 1'b0, 26'h30, 32'h0});
    tick();
    addr_a[0 +: AW] = 26'h40;
    rd_a = 2'b00;
    wait_ack(1'b0, 4'b0001, t);

    // Instance B: reset in the middle of an access
    rst_b = 1'b0;
    addr_b[0 +: AW] = 26'h5;
    rd_b = 4'b0001;
    mdin_b = 32'h55555555;
    tick();
    check("b_mid_read", mrd_b, 1);
    rst_b = 1'b1;
    rd_b = 4'b0000;
    tick();
    check("b_rst_read", mrd_b, 0);
    check("b_rst_ack", ack_b, 0);
    check("b_rst_busy", busy_b, 0);

    // Instance B: all four cores, pointer restarts at core 0
    rst_b = 1'b0;
    mdin_b = 32'hB0B00000;
    addr_b = {26'h103, 26'h102, 26'h101, 26'h100};
    rd_b = 4'b1111;
    exp_ack_b.push_back({4'b0001, 32'hB0B00000});
    exp_ack_b.push_back({4'b0010, 32'hB0B00000});
    exp_ack_b.push_back({4'b0100, 32'hB0B00000});
    exp_ack_b.push_back({4'b1000, 32'hB0B00000});
    wait_ack(1'b1, 4'b1111, t0);
    rd_b = rd_b & ~ack_b;
    for (int i = 1; i < 4; i++) begin
      wait_ack(1'b1, 4'b1111, t1);
      check("b_spacing", t1 - t0, LB + 2);
      check("b_gid", gid_b, i);
      rd_b = rd_b & ~ack_b;
      t0 = t1;
    end

    repeat (5) tick();
    check("q_ack_a_empty", exp_ack_a.size(), 0);
    check("q_mem_a_empty", exp_mem_a.size(), 0);
    check("q_ack_b_empty", exp_ack_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
